uart_tx_buffered: RTL

//  Buffered 8N1 UART transmitter: byte-wide writes from the fabric are queued in a FIFO
//  and serialised onto o_uart_tx back-to-back with no idle gap. Lets the loopback/console

---
 rtl/uart_tx_buffered_pkg.sv | 12 +
 rtl/uart_tx_buffered_sync_fifo.sv | 43 ++++
 rtl/uart_tx_buffered.sv | 99 +++++++++
 3 files changed

// File: rtl/uart_tx_buffered_pkg.sv
// uart_tx_buffered_pkg: serializer state encoding and 8N1 frame constants
package uart_tx_buffered_pkg;
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;
    localparam int DEFAULT_CLKS_PER_BIT = 217;
    localparam int FRAME_BITS = 10;
    localparam int DATA_BITS = FRAME_BITS - 2;
endpackage

// File: rtl/uart_tx_buffered_sync_fifo.sv
// uart_sync_fifo: single-clock FIFO with registered flags and combinational head word
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             wr_ok, rd_ok;
    logic [AW:0]      count_n;
    assign wr_ok   = wr_en & ~full;
    assign rd_ok   = rd_en & ~empty;
    assign count_n = count + {{AW{1'b0}}, wr_ok} - {{AW{1'b0}}, rd_ok};
    assign rd_data = mem[rd_ptr];
    // storage: written only when there is room, so a dropped byte never lands
    always_ff @(posedge i_clk)
        if (wr_ok) mem[wr_ptr] <= wr_data;
    // pointers, occupancy and flags all move together from the same accept/pop decision
    always_ff @(posedge i_clk or posedge i_rst)
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            wr_ptr <= wr_ptr + AW'(wr_ok);
            rd_ptr <= rd_ptr + AW'(rd_ok);
            count  <= count_n;
            full   <= count_n == (AW+1)'(DEPTH);
            empty  <= count_n == '0;
        end
endmodule

// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered: FIFO-buffered 8N1 transmitter sending queued bytes back-to-back
module uart_tx_buffered
    import uart_tx_buffered_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_wr_en,
    input  logic [7:0]                    i_wr_data,
    output logic                          o_full,
    output logic                          o_empty,
    output logic [$clog2(FIFO_DEPTH):0]   o_count,
    output logic                          o_overflow,
    output logic                          o_uart_tx,
    output logic                          o_active,
    output logic                          o_done
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    state_t               state, state_n;
    logic [CW-1:0]        cnt, cnt_n;
    logic [2:0]           idx, idx_n;
    logic [DATA_BITS-1:0] shift, shift_n;
    logic [7:0]           head;
    logic                 pop, bit_last, line_n;
    uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .wr_en   (i_wr_en),
        .wr_data (i_wr_data),
        .rd_en   (pop),
        .rd_data (head),
        .full    (o_full),
        .empty   (o_empty),
        .count   (o_count)
    );
    assign bit_last = cnt == CNT_LAST;
    // next state, bit timing, pop decision and the line level for the current state
    always_comb begin
        state_n = state;
        cnt_n   = (state == S_IDLE || bit_last) ? '0 : cnt + 1'b1;
        idx_n   = idx;
        shift_n = shift;
        pop     = 1'b0;
        line_n  = 1'b1;
        case (state)
            S_IDLE: if (!o_empty) begin
                pop     = 1'b1;
                shift_n = head;
                state_n = S_START;
            end
            S_START: begin
                line_n  = 1'b0;
                state_n = bit_last ? S_DATA : S_START;
            end
            S_DATA: begin
                line_n = shift[0];
                if (bit_last) begin
                    idx_n   = idx + 3'd1;
                    shift_n = shift >> 1;
                    state_n = (idx == 3'd7) ? S_STOP : S_DATA;
                end
            end
            S_STOP: if (bit_last) begin
                pop     = !o_empty;
                shift_n = o_empty ? shift : head;
                state_n = o_empty ? S_IDLE : S_START;
            end
        endcase
    end
    // serializer state; the popped byte lives in shift so later writes cannot touch it
    always_ff @(posedge i_clk or posedge i_rst)
        if (i_rst) begin
            state <= S_IDLE;
            cnt   <= '0;
            idx   <= '0;
            shift <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            idx   <= idx_n;
            shift <= shift_n;
        end
    // flopped line and status so they stay aligned with each other and glitch-free
    always_ff @(posedge i_clk or posedge i_rst)
        if (i_rst) begin
            o_uart_tx  <= 1'b1;
            o_active   <= 1'b0;
            o_done     <= 1'b0;
            o_overflow <= 1'b0;
        end else begin
            o_uart_tx  <= line_n;
            o_active   <= state != S_IDLE;
            o_done     <= state == S_STOP && bit_last;
            o_overflow <= i_wr_en & o_full;
        end
endmodule
